// File: rtl/exu_mul_pipe_if.sv
// Handshake bundle between the issue stage, the pipelined multiplier and the
// writeback arbiter.
//   master : issuer/consumer side (drives ops and out_ready)
//   slave  : multiplier side (drives in_ready, out_valid, out_tag, result)
// Signals:
//   in_valid/in_ready   op handshake
//   in_word/in_high/in_signed  op encoding (32-bit, high half, signed)
//   in_tag, src1, src2  tag and operands
//   out_valid/out_ready result handshake
//   out_tag, result     tag and product slice
interface exu_mul_pipe_if #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 6
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_word;
   logic                  in_high;
   logic                  in_signed;
   logic [TAG_WIDTH-1:0]  in_tag;
   logic [DATA_WIDTH-1:0] src1;
   logic [DATA_WIDTH-1:0] src2;
   logic                  out_valid;
   logic                  out_ready;
   logic [TAG_WIDTH-1:0]  out_tag;
   logic [DATA_WIDTH-1:0] result;

   modport master (
      output in_valid, in_word, in_high, in_signed, in_tag, src1, src2, out_ready,
      input  in_ready, out_valid, out_tag, result
   );

   modport slave (
      input  in_valid, in_word, in_high, in_signed, in_tag, src1, src2, out_ready,
      output in_ready, out_valid, out_tag, result
   );
endinterface

// File: rtl/exu_mul_pipe.sv
// Pipelined LA64 integer multiplier (MUL.W/MULH.W/MULH.WU/MUL.D/MULH.D/MULH.DU).
// Stage 1 captures the op and the operands extended to DATA_WIDTH+1 bits; the
// signed product of the stage-1 operands feeds STAGES-1 further register stages,
// the last of which holds the selected result slice. Each stage advances when
// the stage after it is empty or itself advancing, so bubbles collapse and a
// stalled output freezes the pipe in order.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   flush  kill every in-flight op at the next edge; blocks acceptance this cycle
//   bus    exu_mul_pipe_if.slave: op input and result output handshakes
module exu_mul_pipe #(
   parameter int DATA_WIDTH = 64,
   parameter int STAGES     = 3,
   parameter int TAG_WIDTH  = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   exu_mul_pipe_if.slave  bus
);

   localparam int HW = DATA_WIDTH / 2;
   localparam int OW = DATA_WIDTH + 1;
   localparam int PW = 2 * DATA_WIDTH;

   logic [STAGES:1] vld;
   logic [STAGES:1] adv;
   logic            ld;

   // stage-1 operands and per-stage op metadata (last stage needs none)
   logic signed [OW-1:0]                  a_s1;
   logic signed [OW-1:0]                  b_s1;
   logic [STAGES-1:1]                     word_q;
   logic [STAGES-1:1]                     high_q;
   logic [STAGES-1:1][TAG_WIDTH-1:0]      tag_q;

   // product entering stage k; only the low 2*DATA_WIDTH bits are ever selected
   logic signed [PW-1:0]                  prod_s1;
   logic [STAGES:2][PW-1:0]               p_d;

   function automatic logic signed [OW-1:0] ext_op(
      input logic [DATA_WIDTH-1:0] src,
      input logic                  word,
      input logic                  sgn
   );
      logic          sb;
      logic [OW-1:0] r;
      if (word) begin
         sb = sgn & src[HW-1];
         r  = {{(OW-HW){sb}}, src[HW-1:0]};
      end else begin
         sb = sgn & src[DATA_WIDTH-1];
         r  = {sb, src};
      end
      return r;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sel_res(
      input logic [PW-1:0] p,
      input logic          word,
      input logic          high
   );
      logic [DATA_WIDTH-1:0] r;
      case ({word, high})
         2'b10:   r = {{HW{p[HW-1]}}, p[HW-1:0]};
         2'b11:   r = {{HW{p[DATA_WIDTH-1]}}, p[DATA_WIDTH-1:HW]};
         2'b00:   r = p[DATA_WIDTH-1:0];
         default: r = p[PW-1:DATA_WIDTH];
      endcase
      return r;
   endfunction

   // advance chain evaluated from the output back toward the input
   always_comb begin
      adv         = '0;
      adv[STAGES] = vld[STAGES] & bus.out_ready;
      for (int k = STAGES - 1; k >= 1; k--) begin
         adv[k] = vld[k] & (~vld[k+1] | adv[k+1]);
      end
   end

   assign bus.in_ready  = ~flush & (~vld[1] | adv[1]);
   assign ld            = bus.in_valid & bus.in_ready;
   assign bus.out_valid = vld[STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
      end else if (flush) begin
         vld <= '0;
      end else begin
         vld[1] <= ld | (vld[1] & ~adv[1]);
         for (int k = 2; k <= STAGES; k++) begin
            vld[k] <= adv[k-1] | (vld[k] & ~adv[k]);
         end
      end
   end

   // data registers carry no reset; contents only matter while the stage is valid
   always_ff @(posedge clk) begin
      if (ld) begin
         a_s1      <= ext_op(bus.src1, bus.in_word, bus.in_signed & bus.in_high);
         b_s1      <= ext_op(bus.src2, bus.in_word, bus.in_signed & bus.in_high);
         word_q[1] <= bus.in_word;
         high_q[1] <= bus.in_high;
         tag_q[1]  <= bus.in_tag;
      end
      for (int k = 2; k < STAGES; k++) begin
         if (adv[k-1]) begin
            word_q[k] <= word_q[k-1];
            high_q[k] <= high_q[k-1];
            tag_q[k]  <= tag_q[k-1];
         end
      end
   end

   // 65x65 signed product; modulo 2^PW is exact for the bits we keep
   assign prod_s1 = PW'(a_s1) * PW'(b_s1);
   assign p_d[2]  = prod_s1;

   for (genvar k = 2; k < STAGES; k++) begin : g_mid
      logic [PW-1:0] p_q;
      always_ff @(posedge clk) begin
         if (adv[k-1]) p_q <= p_d[k];
      end
      assign p_d[k+1] = p_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result  <= '0;
         bus.out_tag <= '0;
      end else if (adv[STAGES-1]) begin
         bus.result  <= sel_res(p_d[STAGES], word_q[STAGES-1], high_q[STAGES-1]);
         bus.out_tag <= tag_q[STAGES-1];
      end
   end

endmodule

// File: tb/tb_exu_mul_pipe.sv
// Scoreboard bench for exu_mul_pipe: the driver pushes the hand-computed result
// of every accepted op; a monitor pops and compares at each output handshake.
module tb_exu_mul_pipe;
   localparam int DW     = 64;
   localparam int TW     = 6;
   localparam int STAGES = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   always #5 clk = ~clk;

   exu_mul_pipe_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

   exu_mul_pipe #(.DATA_WIDTH(DW), .STAGES(STAGES), .TAG_WIDTH(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] res;
      bit            lat_chk;
      int            acc_cyc;
   } exp_t;

   typedef struct {
      bit w, h, s;
      logic [DW-1:0] a, b, r;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[12];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   n_out    = 0;
   int   n_acc    = 0;
   bit   stall_prev = 0;
   logic [DW-1:0] prev_res;
   logic [TW-1:0] prev_tag;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic issue(input bit w, input bit h, input bit s, input logic [TW-1:0] tag,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] r, input bit lat);
      exp_t e;
      bus.in_valid  = 1'b1;
      bus.in_word   = w;
      bus.in_high   = h;
      bus.in_signed = s;
      bus.in_tag    = tag;
      bus.src1      = a;
      bus.src2      = b;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.tag = tag; e.res = r; e.lat_chk = lat; e.acc_cyc = cyc;
            sb.push_back(e);
            n_acc++;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: tag %0d not accepted, got in_ready=0, expected 1", tag);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (sb.size() != 0 || bus.out_valid); i++) begin
         @(posedge clk); #2;
      end
      chk("drain_empty", DW'(sb.size()), 0);
   endtask

   // monitor: stable-while-stalled check plus in-order scoreboard pop
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && !flush && bus.out_valid) begin
            if (stall_prev) begin
               chk("stall_result", bus.result, prev_res);
               chk("stall_tag", DW'(bus.out_tag), DW'(prev_tag));
            end
            if (bus.out_ready) begin
               stall_prev = 0;
               n_out++;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: got tag %0d, expected no output", bus.out_tag);
               end else begin
                  mon_e = sb.pop_front();
                  chk("out_tag", DW'(bus.out_tag), DW'(mon_e.tag));
                  chk("result", bus.result, mon_e.res);
                  if (mon_e.lat_chk) chk("latency", DW'(cyc - mon_e.acc_cyc), STAGES);
               end
            end else begin
               stall_prev = 1;
               prev_res   = bus.result;
               prev_tag   = bus.out_tag;
            end
         end else begin
            stall_prev = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_acc, base_out;
      vecs[0]  = '{1, 0, 1, 64'h0000_0000_7FFF_FFFF, 64'h2,                   64'hFFFF_FFFF_FFFF_FFFE};
      vecs[1]  = '{1, 1, 0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[2]  = '{1, 1, 1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'h0};
      vecs[3]  = '{0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[4]  = '{0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      vecs[5]  = '{0, 0, 1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'h0};
      vecs[6]  = '{0, 0, 1, 64'h3,                   64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};
      vecs[7]  = '{0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3,                   64'hFFFF_FFFF_FFFF_FFFF};
      vecs[8]  = '{0, 1, 0, 64'h8000_0000_0000_0000, 64'h4,                   64'h2};
      vecs[9]  = '{1, 0, 0, 64'h1234_5678_8000_0000, 64'hDEAD_BEEF_0000_0003, 64'hFFFF_FFFF_8000_0000};
      vecs[10] = '{1, 1, 1, 64'hFFFF_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000};
      vecs[11] = '{1, 1, 0, 64'h0000_0000_8000_0000, 64'h5555_5555_0000_0002, 64'h1};

      bus.in_valid = 0; bus.in_word = 0; bus.in_high = 0; bus.in_signed = 0;
      bus.in_tag = '0; bus.src1 = '0; bus.src2 = '0; bus.out_ready = 1;

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_out_valid", DW'(bus.out_valid), 0);
      chk("reset_result", bus.result, 0);
      chk("reset_out_tag", DW'(bus.out_tag), 0);
      chk("reset_in_ready", DW'(bus.in_ready), 1);

      // directed ops back-to-back at full throughput, exact latency each
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++)
         issue(vecs[i].w, vecs[i].h, vecs[i].s, TW'(10 + i), vecs[i].a, vecs[i].b, vecs[i].r, 1);
      drain();

      // six ops with the consumer stalled in cycles 2..8
      @(posedge clk); #1;
      base_acc = n_acc;
      base_out = n_out;
      fork
         begin
            for (int k = 1; k <= 6; k++)
               issue(0, 0, 0, TW'(k), DW'(k), DW'(k + 100), DW'(k * (k + 100)), 0);
         end
         begin
            @(posedge clk); #1;
            bus.out_ready = 0;
            repeat (7) @(posedge clk);
            #1;
            bus.out_ready = 1;
         end
         begin
            for (int i = 0; i < 20; i++) begin
               @(negedge clk);
               if (!bus.in_ready) begin
                  chk("fill_depth", DW'(n_acc - base_acc), STAGES);
                  break;
               end
            end
         end
      join
      drain();
      chk("stall_out_count", DW'(n_out - base_out), 6);

      // flush with three ops in flight and an op offered in the same cycle
      @(posedge clk); #1;
      base_out = n_out;
      issue(0, 0, 0, TW'(7), 64'd5, 64'd5, 64'd25, 0);
      issue(0, 0, 0, TW'(8), 64'd6, 64'd6, 64'd36, 0);
      issue(0, 0, 0, TW'(9), 64'd7, 64'd7, 64'd49, 0);
      flush = 1'b1;
      bus.in_valid = 1'b1; bus.in_word = 0; bus.in_high = 0; bus.in_tag = TW'(42);
      bus.src1 = 64'd9; bus.src2 = 64'd9;
      @(negedge clk);
      chk("flush_in_ready", DW'(bus.in_ready), 0);
      chk("flush_pre_out_valid", DW'(bus.out_valid), 1);
      @(posedge clk); #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      chk("flush_out_valid", DW'(bus.out_valid), 0);
      issue(0, 0, 1, TW'(21), 64'd7, 64'd6, 64'd42, 1);
      drain();
      chk("flush_out_count", DW'(n_out - base_out), 1);

      // asynchronous reset with the pipe full and the output stalled
      bus.out_ready = 0;
      issue(0, 0, 0, TW'(30), 64'd11, 64'd3, 64'd33, 0);
      issue(0, 0, 0, TW'(31), 64'd12, 64'd3, 64'd36, 0);
      issue(0, 0, 0, TW'(32), 64'd13, 64'd3, 64'd39, 0);
      #2;
      chk("prereset_out_valid", DW'(bus.out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", DW'(bus.out_valid), 0);
      chk("arst_result", bus.result, 0);
      chk("arst_out_tag", DW'(bus.out_tag), 0);
      chk("arst_in_ready", DW'(bus.in_ready), 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1;
      @(posedge clk); #1;
      issue(1, 0, 1, TW'(33), 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0005,
            64'hFFFF_FFFF_FFFF_FFFB, 1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
